// File: rtl/usb_buffer_pkg.sv
// Shared sizing for the USB data buffer; the AHB slave imports this too so
// its occupancy register matches the buffer's count width.
package usb_buffer_pkg;

   localparam int BUF_DEPTH = 64;
   localparam int BUF_AW    = 6;
   localparam int BUF_OCC_W = 7;

   typedef logic [BUF_OCC_W-1:0] buf_ptr_t;
   typedef logic [7:0]           buf_byte_t;

   localparam buf_ptr_t BUF_FULL_OCC = buf_ptr_t'(BUF_DEPTH);

endpackage

// File: rtl/usb_buf_ptr.sv
// Buffer pointer: 6 address bits plus a wrap bit, so full and empty are
// distinguishable by plain subtraction of write and read pointers.
module usb_buf_ptr
   import usb_buffer_pkg::*;
(
   input  logic     clk,
   input  logic     n_rst,
   input  logic     i_clear,
   input  logic     i_inc,
   output buf_ptr_t o_ptr
);

   buf_ptr_t r_ptr;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ptr <= '0;
      end else if (i_clear) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + buf_ptr_t'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared 64-byte FIFO between the AHB slave and the USB RX/TX packet paths.
// Either side may push or pop; head byte is presented first-word-fall-through.
module usb_data_buffer
   import usb_buffer_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic       store_tx_data,
   input  logic [7:0] tx_data,
   input  logic       get_rx_data,
   output logic [7:0] rx_data,
   input  logic       store_rx_packet_data,
   input  logic [7:0] rx_packet_data,
   input  logic       get_tx_packet_data,
   output logic [7:0] tx_packet_data,
   output logic [6:0] buffer_occupancy,
   output logic       overflow,
   output logic       underflow
);

   buf_byte_t r_mem [BUF_DEPTH];
   logic      r_overflow;
   logic      r_underflow;

   buf_ptr_t  w_wr_ptr;
   buf_ptr_t  w_rd_ptr;
   buf_ptr_t  w_occ;
   logic      w_push;
   logic      w_pop;
   buf_byte_t w_push_data;
   logic      w_full;
   logic      w_empty;
   logic      w_push_ok;
   logic      w_pop_ok;
   buf_byte_t w_head;

   assign w_push      = store_tx_data | store_rx_packet_data;
   assign w_pop       = get_rx_data | get_tx_packet_data;
   assign w_push_data = store_tx_data ? tx_data : rx_packet_data;

   assign w_occ   = w_wr_ptr - w_rd_ptr;
   assign w_full  = (w_occ == BUF_FULL_OCC);
   assign w_empty = (w_occ == '0);

   // A pop on a full buffer frees the slot the same-cycle push lands in.
   assign w_pop_ok  = w_pop & ~w_empty & ~clear;
   assign w_push_ok = w_push & ~clear & (~w_full | w_pop);

   usb_buf_ptr u_wr_ptr (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_clear (clear),
      .i_inc   (w_push_ok),
      .o_ptr   (w_wr_ptr)
   );

   usb_buf_ptr u_rd_ptr (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_clear (clear),
      .i_inc   (w_pop_ok),
      .o_ptr   (w_rd_ptr)
   );

   // Storage is deliberately left out of reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[w_wr_ptr[BUF_AW-1:0]] <= w_push_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= w_push & ~clear & w_full & ~w_pop;
         r_underflow <= w_pop & ~clear & w_empty;
      end
   end

   assign w_head = w_empty ? 8'h00 : r_mem[w_rd_ptr[BUF_AW-1:0]];

   assign rx_data          = w_head;
   assign tx_packet_data   = w_head;
   assign buffer_occupancy = w_occ;
   assign overflow         = r_overflow;
   assign underflow        = r_underflow;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: one task per scenario, inline checks.
module tb_usb_data_buffer;

   logic       clk;
   logic       n_rst;
   logic       clear;
   logic       store_tx_data;
   logic [7:0] tx_data;
   logic       get_rx_data;
   logic [7:0] rx_data;
   logic       store_rx_packet_data;
   logic [7:0] rx_packet_data;
   logic       get_tx_packet_data;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       overflow;
   logic       underflow;

   int tests_run;
   int tests_failed;

   usb_data_buffer dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .buffer_occupancy     (buffer_occupancy),
      .overflow             (overflow),
      .underflow            (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of strobes, clock it, sample 1ns after the edge, idle inputs.
   task automatic step(input logic s_tx, input logic [7:0] d_tx,
                       input logic s_rx, input logic [7:0] d_rx,
                       input logic g_rx, input logic g_tx, input logic clr);
      store_tx_data        = s_tx;
      tx_data              = d_tx;
      store_rx_packet_data = s_rx;
      rx_packet_data       = d_rx;
      get_rx_data          = g_rx;
      get_tx_packet_data   = g_tx;
      clear                = clr;
      @(posedge clk);
      #1;
      store_tx_data        = 1'b0;
      store_rx_packet_data = 1'b0;
      get_rx_data          = 1'b0;
      get_tx_packet_data   = 1'b0;
      clear                = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      #12;
      tests_run++;
      if (buffer_occupancy !== 7'd0) begin
         tests_failed++;
         $display("FAIL reset_occ got %0d exp 0", buffer_occupancy);
      end
      tests_run++;
      if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data got %h/%h exp 00/00", rx_data, tx_packet_data);
      end
      tests_run++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", overflow, underflow);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_push();
      step(1, 8'hA5, 0, 8'h00, 0, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd1) begin
         tests_failed++;
         $display("FAIL push_occ got %0d exp 1", buffer_occupancy);
      end
      tests_run++;
      if (rx_data !== 8'hA5 || tx_packet_data !== 8'hA5) begin
         tests_failed++;
         $display("FAIL push_head got %h/%h exp a5/a5", rx_data, tx_packet_data);
      end
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL push_drain got occ=%0d rx=%h unf=%b exp 0/00/0",
                  buffer_occupancy, rx_data, underflow);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 64; i++) step(0, 8'h00, 1, 8'(i), 0, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd64 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_occ got occ=%0d ovf=%b exp 64/0", buffer_occupancy, overflow);
      end
      step(0, 8'h00, 1, 8'hFF, 0, 0, 0);
      tests_run++;
      if (overflow !== 1'b1 || buffer_occupancy !== 7'd64 || rx_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL ovf_pulse got ovf=%b occ=%0d head=%h exp 1/64/00",
                  overflow, buffer_occupancy, rx_data);
      end
      step(0, 8'h00, 0, 8'h00, 0, 0, 0);
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_once got %b exp 0", overflow);
      end
      for (int i = 0; i < 64; i++) begin
         tests_run++;
         if (tx_packet_data !== 8'(i) || rx_data !== 8'(i)) begin
            tests_failed++;
            $display("FAIL drain_order[%0d] got %h/%h exp %h", i, rx_data, tx_packet_data, 8'(i));
         end
         step(0, 8'h00, 0, 8'h00, 0, 1, 0);
      end
      tests_run++;
      if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL drain_empty got occ=%0d head=%h exp 0/00", buffer_occupancy, tx_packet_data);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 64; i++) step(0, 8'h00, 1, 8'(i + 8'h40), 0, 0, 0);
      step(1, 8'h77, 0, 8'h00, 1, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd64 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pp got occ=%0d ovf=%b exp 64/0", buffer_occupancy, overflow);
      end
      tests_run++;
      if (rx_data !== 8'h41) begin
         tests_failed++;
         $display("FAIL full_pp_head got %h exp 41", rx_data);
      end
      for (int i = 0; i < 63; i++) step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      tests_run++;
      if (rx_data !== 8'h77 || buffer_occupancy !== 7'd1) begin
         tests_failed++;
         $display("FAIL full_pp_last got head=%h occ=%0d exp 77/1", rx_data, buffer_occupancy);
      end
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
   endtask

   task automatic test_dual_strobes();
      step(1, 8'h11, 1, 8'h22, 0, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd1 || rx_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL dual_push got occ=%0d head=%h exp 1/11", buffer_occupancy, rx_data);
      end
      step(0, 8'h00, 1, 8'h33, 0, 0, 0);
      step(0, 8'h00, 0, 8'h00, 1, 1, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h33) begin
         tests_failed++;
         $display("FAIL dual_pop got occ=%0d head=%h exp 1/33", buffer_occupancy, tx_packet_data);
      end
      step(0, 8'h00, 0, 8'h00, 1, 1, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd0 || underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL dual_pop2 got occ=%0d unf=%b exp 0/0", buffer_occupancy, underflow);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 0, 8'h00, 0, 0, 0);
      tests_run++;
      if (buffer_occupancy !== 7'd10) begin
         tests_failed++;
         $display("FAIL clr_load got %0d exp 10", buffer_occupancy);
      end
      step(1, 8'hEE, 0, 8'h00, 0, 0, 1);
      tests_run++;
      if (buffer_occupancy !== 7'd0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_push got occ=%0d ovf=%b exp 0/0", buffer_occupancy, overflow);
      end
      step(0, 8'h00, 0, 8'h00, 1, 0, 0);
      tests_run++;
      if (underflow !== 1'b1 || rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL clr_unf got unf=%b data=%h/%h exp 1/00/00",
                  underflow, rx_data, tx_packet_data);
      end
      step(0, 8'h00, 0, 8'h00, 0, 1, 1);
      tests_run++;
      if (underflow !== 1'b0 || buffer_occupancy !== 7'd0) begin
         tests_failed++;
         $display("FAIL clr_mask got unf=%b occ=%0d exp 0/0", underflow, buffer_occupancy);
      end
   endtask

   task automatic test_wrap_reset();
      logic [7:0] q[$];
      logic [7:0] v;
      for (int i = 0; i < 3; i++) begin
         v = 8'(8'hC0 + i);
         step(1, v, 0, 8'h00, 0, 0, 0);
         q.push_back(v);
      end
      for (int i = 0; i < 200; i++) begin
         if (i == 100) begin
            store_tx_data = 1'b1;
            tx_data       = 8'h5A;
            get_rx_data   = 1'b1;
            #2;
            n_rst = 1'b0;
            #1;
            tests_run++;
            if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
               tests_failed++;
               $display("FAIL wrap_rst got occ=%0d data=%h/%h exp 0/00/00",
                        buffer_occupancy, rx_data, tx_packet_data);
            end
            @(negedge clk);
            store_tx_data = 1'b0;
            get_rx_data   = 1'b0;
            @(negedge clk);
            n_rst = 1'b1;
            @(posedge clk);
            #1;
            tests_run++;
            if (buffer_occupancy !== 7'd0) begin
               tests_failed++;
               $display("FAIL wrap_rst_hold got %0d exp 0", buffer_occupancy);
            end
            q.delete();
            for (int k = 0; k < 3; k++) begin
               v = 8'(8'hD0 + k);
               step(1, v, 0, 8'h00, 0, 0, 0);
               q.push_back(v);
            end
         end
         v = 8'(i * 7 + 1);
         tests_run++;
         if (rx_data !== q[0]) begin
            tests_failed++;
            $display("FAIL wrap_order[%0d] got %h exp %h", i, rx_data, q[0]);
         end
         step(0, 8'h00, 1, v, 0, 1, 0);
         void'(q.pop_front());
         q.push_back(v);
      end
      tests_run++;
      if (buffer_occupancy !== 7'd3) begin
         tests_failed++;
         $display("FAIL wrap_occ got %0d exp 3", buffer_occupancy);
      end
   endtask

   initial begin
      tests_run            = 0;
      tests_failed         = 0;
      clear                = 1'b0;
      store_tx_data        = 1'b0;
      tx_data              = 8'h00;
      get_rx_data          = 1'b0;
      store_rx_packet_data = 1'b0;
      rx_packet_data       = 8'h00;
      get_tx_packet_data   = 1'b0;
      test_reset();
      test_single_push();
      test_fill_overflow();
      test_full_push_pop();
      test_dual_strobes();
      test_clear();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
